// File: rtl/timer_opt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// timer_opt_ctrl_pkg
//   Shared definitions for the option/countdown controller:
//   - FSM state encodings (fixed 3-bit codes kept compatible with the
//     original clock-timer option FSM)
//   - calc_load(): countdown load value for a confirmed option
// ---------------------------------------------------------------------------
package timer_opt_ctrl_pkg;

  localparam logic [2:0] ST_SEL       = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_CONFIRM   = 3'd2;
  localparam logic [2:0] ST_LOCKED    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_PAUSE     = 3'd5;
  localparam logic [2:0] ST_RST_PULSE = 3'd6;

  // Full-width product; the caller truncates to the countdown width, so a
  // product that wraps past the counter range is loaded as-is (no saturation).
  function automatic logic [31:0] calc_load(input logic [31:0] opt,
                                            input logic [31:0] step);
    return (opt + 32'd1) * step;
  endfunction

endpackage

// File: rtl/timer_opt_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_opt_ctrl_if
//   Board-side signal bundle of the option/countdown controller.
//   master : drives optiune_user, validare_fsm, switch; observes the outputs
//   slave  : the controller (receives inputs, drives valid, fsm_reset,
//            optiune, count, tick, done)
// ---------------------------------------------------------------------------
interface timer_opt_ctrl_if #(
  parameter int OPT_W = 3,
  parameter int CNT_W = 8
);
  logic [OPT_W-1:0] optiune_user;
  logic             validare_fsm;
  logic             switch;
  logic             valid;
  logic             fsm_reset;
  logic [OPT_W-1:0] optiune;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             done;

  modport master (
    output optiune_user, validare_fsm, switch,
    input  valid, fsm_reset, optiune, count, tick, done
  );

  modport slave (
    input  optiune_user, validare_fsm, switch,
    output valid, fsm_reset, optiune, count, tick, done
  );
endinterface

// File: rtl/timer_opt_ctrl_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Emits a one-cycle tick every PRESC enabled clock cycles.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : restart the period (takes priority over en)
//   en       : count this cycle; when low the phase is frozen
//   tick     : combinational pulse on the last enabled cycle of a period
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESC = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(PRESC - 1));
  assign tick   = en && !clr && at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= at_end ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/timer_opt_ctrl.sv
// ---------------------------------------------------------------------------
// timer_opt_ctrl
//   Qualifies a user option (stability window + active-low validate
//   press/release), latches it, and runs a prescaled countdown whose load is
//   (optiune+1)*LOAD_STEP truncated to CNT_W bits.
//   clk, rst : single clock, asynchronous active-low reset
//   bus      : timer_opt_ctrl_if.slave
//              in : optiune_user (async, 2-flop synced), validare_fsm
//                   (active-low button), switch (1 = run, 0 = pause)
//              out: valid, fsm_reset (pulse), optiune, count, tick (pulse),
//                   done (pulse)
//   Optional build macro: VALID_DEBOUNCE_EN -- the synced validate level must
//   hold DEB_CYC consecutive cycles before the press level follows it.
// ---------------------------------------------------------------------------
module timer_opt_ctrl
  import timer_opt_ctrl_pkg::*;
#(
  parameter int OPT_W      = 3,
  parameter int STABLE_CYC = 16,
  parameter int DEB_CYC    = 8,
  parameter int PRESC      = 50,
  parameter int CNT_W      = 8,
  parameter int LOAD_STEP  = 10,
  parameter int RESET_OPT  = 0
) (
  input logic             clk,
  input logic             rst,
  timer_opt_ctrl_if.slave bus
);
  if (STABLE_CYC < 1 || DEB_CYC < 1 || PRESC < 1 || CNT_W > 32) begin : g_param_check
    $error("timer_opt_ctrl: illegal parameter combination");
  end

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  logic [OPT_W-1:0] opt_meta, opt_s, opt_q;
  logic             val_meta, val_s;
  logic             press_lvl, press_d;
  logic             opt_chg, press_rise, tick_w;
  logic [2:0]       state;
  logic [SW-1:0]    stab_cnt;
  logic [OPT_W-1:0] cand;
  logic             valid_q;
  logic [OPT_W-1:0] optiune_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] load_val;

  // Synchronisers. opt_q is one more stage so opt_chg flags any change of the
  // synced option. The button resets to its idle (released) level so leaving
  // reset never looks like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opt_meta <= '0;
      opt_s    <= '0;
      opt_q    <= '0;
      val_meta <= 1'b1;
      val_s    <= 1'b1;
    end else begin
      opt_meta <= bus.optiune_user;
      opt_s    <= opt_meta;
      opt_q    <= opt_s;
      val_meta <= bus.validare_fsm;
      val_s    <= val_meta;
    end
  end

`ifdef VALID_DEBOUNCE_EN
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  logic [DW-1:0] deb_cnt;

  // press_lvl follows ~val_s only after DEB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt   <= '0;
      press_lvl <= 1'b0;
    end else if (~val_s == press_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYC - 1)) begin
      deb_cnt   <= '0;
      press_lvl <= ~val_s;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  assign press_lvl = ~val_s;
`endif

  // A press is acted on only as an edge, so a button still held after an
  // aborted confirm cannot re-confirm a new option without being released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) press_d <= 1'b0;
    else      press_d <= press_lvl;
  end

  assign opt_chg    = (opt_s != opt_q);
  assign press_rise = press_lvl && !press_d;
  assign load_val   = CNT_W'(calc_load(32'(optiune_q), 32'(LOAD_STEP)));

  tick_prescaler #(.PRESC(PRESC)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_LOCKED),
    .en   ((state == ST_RUN) && bus.switch),
    .tick (tick_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SEL;
      stab_cnt  <= '0;
      cand      <= '0;
      valid_q   <= 1'b0;
      optiune_q <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        ST_SEL: begin
          if (opt_chg) begin
            stab_cnt <= '0;
          end else if (stab_cnt == SW'(STABLE_CYC - 1)) begin
            stab_cnt <= '0;
            state    <= ST_ARMED;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        ST_ARMED: begin
          if (opt_chg) begin
            state <= ST_SEL;
          end else if (press_rise) begin
            cand  <= opt_s;
            state <= ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (opt_chg) begin
            state <= ST_SEL;
          end else if (!press_lvl) begin
            if (cand == OPT_W'(RESET_OPT)) begin
              state <= ST_RST_PULSE;
            end else begin
              optiune_q <= cand;
              valid_q   <= 1'b1;
              count_q   <= '0;
              state     <= ST_LOCKED;
            end
          end
        end
        ST_RST_PULSE: begin
          valid_q   <= 1'b0;
          optiune_q <= '0;
          count_q   <= '0;
          state     <= ST_SEL;
        end
        ST_LOCKED: begin
          if (opt_chg) begin
            state <= ST_SEL;
          end else if (bus.switch) begin
            // A zero load finishes immediately (done pulses) and stays here.
            count_q <= load_val;
            if (load_val != '0) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.switch) begin
            state <= ST_PAUSE;
          end else if (tick_w) begin
            if (count_q == CNT_W'(1)) begin
              count_q <= '0;
              state   <= ST_LOCKED;
            end else begin
              count_q <= count_q - 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (opt_chg)         state <= ST_SEL;
          else if (bus.switch) state <= ST_RUN;
        end
        default: state <= ST_SEL;
      endcase
    end
  end

  assign bus.valid     = valid_q;
  assign bus.optiune   = optiune_q;
  assign bus.count     = count_q;
  assign bus.tick      = tick_w;
  assign bus.fsm_reset = (state == ST_RST_PULSE);
  assign bus.done      = ((state == ST_RUN) && bus.switch && tick_w && (count_q == CNT_W'(1)))
                      || ((state == ST_LOCKED) && !opt_chg && bus.switch && (load_val == '0));
endmodule

// File: tb/tb_timer_opt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_opt_ctrl
//   Self-checking bench for timer_opt_ctrl with PRESC=4, STABLE_CYC=4,
//   DEB_CYC=3, LOAD_STEP=3. Expected countdown values are queued when the
//   run is started and popped as ticks are observed. Honours
//   VALID_DEBOUNCE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_timer_opt_ctrl;
  localparam int OPT_W      = 3;
  localparam int CNT_W      = 8;
  localparam int PRESC      = 4;
  localparam int STABLE_CYC = 4;
  localparam int DEB_CYC    = 3;
  localparam int LOAD_STEP  = 3;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   rst_pulse_cnt = 0;
  int   tick_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];

  timer_opt_ctrl_if #(.OPT_W(OPT_W), .CNT_W(CNT_W)) bus ();

  timer_opt_ctrl #(
    .OPT_W(OPT_W), .STABLE_CYC(STABLE_CYC), .DEB_CYC(DEB_CYC), .PRESC(PRESC),
    .CNT_W(CNT_W), .LOAD_STEP(LOAD_STEP), .RESET_OPT(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fsm_reset === 1'b1) rst_pulse_cnt++;
    if (bus.tick === 1'b1)      tick_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stable option, press for press_cyc cycles, release, settle.
  task automatic confirm_opt(input logic [OPT_W-1:0] opt, input int press_cyc);
    bus.optiune_user = opt;
    step(10);
    bus.validare_fsm = 1'b0;
    step(press_cyc);
    bus.validare_fsm = 1'b1;
    step(12);
  endtask

  // Consume n queued expectations, one per observed tick.
  task automatic run_ticks(input int n, input int budget);
    int seen = 0;
    int waited = 0;
    int last = -1;
    logic [CNT_W-1:0] exp;
    while (seen < n && waited < budget) begin
      if (bus.tick === 1'b1) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (bus.done !== (exp == '0)) begin
          n_err++;
          $display("FAIL done_at_tick: got %b want %b (count->%0d)", bus.done, exp == '0, exp);
        end
        if (last >= 0) begin
          n_vec++;
          if (waited - last !== PRESC) begin
            n_err++;
            $display("FAIL tick_spacing: got %0d want %0d", waited - last, PRESC);
          end
        end
        last = waited;
        step(1);
        waited++;
        n_vec++;
        if (bus.count !== exp) begin
          n_err++;
          $display("FAIL count_after_tick: got %0d want %0d", bus.count, exp);
        end
        seen++;
      end else begin
        step(1);
        waited++;
      end
    end
    if (seen < n) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got %0d ticks want %0d", seen, n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.optiune_user = '0;
    bus.validare_fsm = 1'b1;
    bus.switch = 1'b0;
    step(3);
    n_vec++; if (bus.valid !== 1'b0)     begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.optiune !== '0)     begin n_err++; $display("FAIL rst_optiune: got %0d want 0", bus.optiune); end
    n_vec++; if (bus.count !== '0)       begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.fsm_reset !== 1'b0) begin n_err++; $display("FAIL rst_fsm_reset: got %b want 0", bus.fsm_reset); end
    n_vec++; if (bus.tick !== 1'b0)      begin n_err++; $display("FAIL rst_tick: got %b want 0", bus.tick); end
    n_vec++; if (bus.done !== 1'b0)      begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done); end
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_confirm();
    int snap = rst_pulse_cnt;
    confirm_opt(3'b001, 5);
    n_vec++; if (bus.valid !== 1'b1)   begin n_err++; $display("FAIL confirm_valid: got %b want 1", bus.valid); end
    n_vec++; if (bus.optiune !== 3'd1) begin n_err++; $display("FAIL confirm_optiune: got %0d want 1", bus.optiune); end
    n_vec++; if (rst_pulse_cnt - snap !== 0) begin n_err++; $display("FAIL confirm_no_reset: got %0d pulses want 0", rst_pulse_cnt - snap); end
  endtask

  task automatic test_change_during_press();
    bus.optiune_user = 3'b011;
    step(10);
    bus.validare_fsm = 1'b0;
    step(6);
    bus.optiune_user = 3'b100;
    step(6);
    bus.validare_fsm = 1'b1;
    step(12);
    n_vec++; if (bus.optiune !== 3'd1) begin n_err++; $display("FAIL abort_optiune: got %0d want 1", bus.optiune); end
    n_vec++; if (bus.valid !== 1'b1)   begin n_err++; $display("FAIL abort_valid: got %b want 1", bus.valid); end
  endtask

  task automatic test_reset_opt();
    int snap = rst_pulse_cnt;
    confirm_opt(3'b000, 5);
    step(3);
    n_vec++; if (rst_pulse_cnt - snap !== 1) begin n_err++; $display("FAIL reset_pulse_len: got %0d cycles want 1", rst_pulse_cnt - snap); end
    n_vec++; if (bus.valid !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.optiune !== 3'd0) begin n_err++; $display("FAIL reset_optiune: got %0d want 0", bus.optiune); end
  endtask

  task automatic test_run();
    confirm_opt(3'b010, 5);
    n_vec++; if (bus.optiune !== 3'd2) begin n_err++; $display("FAIL run_optiune: got %0d want 2", bus.optiune); end
    n_vec++; if (bus.count !== '0)     begin n_err++; $display("FAIL run_count_pre: got %0d want 0", bus.count); end
    // load = (2+1)*3 = 9; each tick decrements down to 0
    for (int v = 8; v >= 0; v--) exp_q.push_back(CNT_W'(v));
    bus.switch = 1'b1;
    run_ticks(9, 100);
    bus.switch = 1'b0;
    step(2);
    n_vec++; if (bus.count !== '0)   begin n_err++; $display("FAIL run_count_end: got %0d want 0", bus.count); end
    n_vec++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL run_valid_end: got %b want 1", bus.valid); end
  endtask

  task automatic test_pause();
    int snap;
    for (int v = 8; v >= 5; v--) exp_q.push_back(CNT_W'(v));
    bus.switch = 1'b1;
    run_ticks(4, 60);
    bus.switch = 1'b0;
    snap = tick_cnt;
    step(20);
    n_vec++; if (bus.count !== 8'd5)      begin n_err++; $display("FAIL pause_count: got %0d want 5", bus.count); end
    n_vec++; if (tick_cnt - snap !== 0)   begin n_err++; $display("FAIL pause_ticks: got %0d want 0", tick_cnt - snap); end
    for (int v = 4; v >= 0; v--) exp_q.push_back(CNT_W'(v));
    bus.switch = 1'b1;
    run_ticks(5, 60);
    bus.switch = 1'b0;
    step(2);
  endtask

  task automatic test_mid_run_reset();
    bus.switch = 1'b1;
    step(10);
    n_vec++; if (bus.count === '0) begin n_err++; $display("FAIL midrst_running: got count %0d want nonzero", bus.count); end
    rst = 1'b0;
    #1;
    n_vec++; if (bus.valid !== 1'b0)     begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.optiune !== '0)     begin n_err++; $display("FAIL midrst_optiune: got %0d want 0", bus.optiune); end
    n_vec++; if (bus.count !== '0)       begin n_err++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
    n_vec++; if (bus.fsm_reset !== 1'b0) begin n_err++; $display("FAIL midrst_fsm_reset: got %b want 0", bus.fsm_reset); end
    bus.switch = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  task automatic test_short_press();
    bus.optiune_user = 3'b101;
    step(10);
    bus.validare_fsm = 1'b0;
    step(2);
    bus.validare_fsm = 1'b1;
    step(12);
`ifdef VALID_DEBOUNCE_EN
    n_vec++; if (bus.valid !== 1'b0)   begin n_err++; $display("FAIL glitch_valid: got %b want 0", bus.valid); end
    n_vec++; if (bus.optiune !== 3'd0) begin n_err++; $display("FAIL glitch_optiune: got %0d want 0", bus.optiune); end
`else
    n_vec++; if (bus.valid !== 1'b1)   begin n_err++; $display("FAIL short_press_valid: got %b want 1", bus.valid); end
    n_vec++; if (bus.optiune !== 3'd5) begin n_err++; $display("FAIL short_press_optiune: got %0d want 5", bus.optiune); end
`endif
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_change_during_press();
    test_reset_opt();
    test_run();
    test_pause();
    test_mid_run_reset();
    test_short_press();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
